// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: the NOP encoding used
// for bubbles, the fetch FSM state encoding, the PC increment and a helper
// that tells whether a byte PC falls outside the instruction ROM.
// Optional feature macro: IF_FAULT_EN (consumed by if_stage and pc_reg).
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetchState_t;

  // A byte PC is in range when every bit above the word index is zero.
  function automatic logic pcOutOfRange(input logic [31:0] pc,
                                        input int unsigned addrWidth);
    logic [31:0] upper;
    upper = pc >> (addrWidth + 2);
    return (upper != 32'd0);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   master : the fetch stage itself (drives imem_addr, id_*, fault)
//   slave  : the surrounding pipeline / ROM (drives control and imem_data)
// Signals:
//   stall, flush, redirect_valid, redirect_pc : pipeline control into fetch
//   imem_addr (word address), imem_data       : instruction ROM port
//   id_valid, id_inst, id_pc, id_pc_plus4     : IF/ID pipeline register
//   fault                                     : sticky fetch fault
// ---------------------------------------------------------------------------
interface if_stage_if;

  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fault;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, imem_data,
    output imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fault
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fault
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Byte-addressed program counter with its next-PC selection.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (loads RESET_PC)
//   i_hold            : keep the current PC (stall, BOOT, FAULT, fault entry)
//   i_redirect_valid  : load i_redirect_pc this cycle, overrides i_hold
//   i_redirect_pc     : byte target PC
//   o_pc              : current PC
// Macro IF_FAULT_EN: when undefined the target is forced word aligned,
// when defined the raw target is loaded so misalignment can be detected.
// ---------------------------------------------------------------------------
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic [31:0] w_target;

`ifdef IF_FAULT_EN
  assign w_target = i_redirect_pc;
`else
  // Without fault detection a misaligned target could never be reported,
  // so the low two bits are dropped and the PC stays word aligned.
  logic w_unusedLowBits;
  assign w_target        = {i_redirect_pc[31:2], 2'b00};
  assign w_unusedLowBits = ^i_redirect_pc[1:0];
`endif

  // Next-PC mux: a redirect beats a hold, otherwise step by one word.
  // The add wraps naturally at 32 bits (FFFF_FFFC -> 0).
  always_comb begin
    w_nextPc = r_pc + PC_INC;
    if (i_redirect_valid) begin
      w_nextPc = w_target;
    end else if (i_hold) begin
      w_nextPc = r_pc;
    end
  end

  // PC register with synchronous reset to the boot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: drives the ROM word address from the PC and
// captures {pc, instruction, pc+4} into the IF/ID register once per cycle.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : if_stage_if.master (control in, ROM port, IF/ID outputs, fault)
// Parameters:
//   RESET_PC   : byte PC loaded on reset
//   ADDR_WIDTH : ROM word-index width, must match the ROM
// Macro IF_FAULT_EN: enables the FAULT state and the sticky fault flag for
// misaligned or out-of-range PCs; when undefined fault is constant 0.
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 6
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  fetchState_t r_state;
  logic        r_idValid;
  logic [31:0] r_idInst;
  logic [31:0] r_idPc;
  logic [31:0] r_idPcPlus4;
  logic [31:0] w_pc;
  logic        w_hold;
  logic        w_outOfRange;

  assign w_outOfRange = pcOutOfRange(w_pc, ADDR_WIDTH);

`ifdef IF_FAULT_EN
  logic r_fault;
  logic w_faultTrip;

  assign w_faultTrip = (r_state == RUN) && ((w_pc[1:0] != 2'b00) || w_outOfRange);
  assign w_hold      = bus.stall || (r_state != RUN) || w_faultTrip;
`else
  // Out-of-range fetches simply latch whatever the ROM returns here.
  logic w_unusedRange;
  assign w_unusedRange = w_outOfRange;
  assign w_hold        = bus.stall || (r_state != RUN);
`endif

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .clk              (clk),
    .rst              (rst),
    .i_hold           (w_hold),
    .i_redirect_valid (bus.redirect_valid),
    .i_redirect_pc    (bus.redirect_pc),
    .o_pc             (w_pc)
  );

  // Fetch FSM and IF/ID register. A redirect squashes the slot and lands
  // in RUN from any state; BOOT is a single bubble cycle after reset;
  // in RUN flush beats stall, and stall alone freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_idValid   <= 1'b0;
      r_idInst    <= NOP;
      r_idPc      <= 32'd0;
      r_idPcPlus4 <= 32'd0;
    end else if (bus.redirect_valid) begin
      r_state   <= RUN;
      r_idValid <= 1'b0;
      r_idInst  <= NOP;
    end else begin
      case (r_state)
        BOOT: begin
          r_state   <= RUN;
          r_idValid <= 1'b0;
        end
        RUN: begin
`ifdef IF_FAULT_EN
          if (w_faultTrip) begin
            r_state   <= FAULT;
            r_idValid <= 1'b0;
          end else
`endif
          if (bus.flush) begin
            r_idValid <= 1'b0;
            r_idInst  <= NOP;
          end else if (!bus.stall) begin
            r_idValid   <= 1'b1;
            r_idInst    <= bus.imem_data;
            r_idPc      <= w_pc;
            r_idPcPlus4 <= w_pc + PC_INC;
          end
        end
        default: begin
          r_idValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FAULT_EN
  // Sticky fault flag: set on the cycle the FSM enters FAULT, cleared only
  // by reset or a redirect.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      r_fault <= 1'b0;
    end else if (w_faultTrip) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.imem_addr   = {2'b00, w_pc[31:2]};
  assign bus.id_valid    = r_idValid;
  assign bus.id_inst     = r_idInst;
  assign bus.id_pc       = r_idPc;
  assign bus.id_pc_plus4 = r_idPcPlus4;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage (default build, IF_FAULT_EN undefined).
// A behavioural model predicts the IF/ID outputs for every driven cycle and
// pushes them to a scoreboard queue; after the clock edge the entry is
// popped and compared. Directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ADDR_WIDTH = 6;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        fault;
    logic [31:0] addr;
  } expT;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  expT  scoreboard[$];

  logic [31:0] mPc;
  logic        mBoot;
  logic        mValid;
  logic [31:0] mInst;
  logic [31:0] mIdPc;
  logic [31:0] mIdPc4;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC   (RESET_PC),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word k holds 0x100 + k, anything beyond the ROM reads 0.
  function automatic logic [31:0] romWord(input logic [31:0] wordAddr);
    if ((wordAddr >> ADDR_WIDTH) != 32'd0) return 32'd0;
    return 32'h100 + wordAddr;
  endfunction

  // ROM latches on the falling edge, giving data before the next rise.
  always @(negedge clk) begin
    bus.imem_data <= romWord(bus.imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, predict the result, wait for the edge and
  // compare the oldest scoreboard entry against the DUT.
  task automatic applyStimulus(input logic s, input logic f, input logic rv,
                               input logic [31:0] rp, input logic r);
    expT e;
    rst                = r;
    bus.stall          = s;
    bus.flush          = f;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;

    if (r) begin
      mPc = RESET_PC; mBoot = 1'b1; mValid = 1'b0;
      mInst = 32'd0; mIdPc = 32'd0; mIdPc4 = 32'd0;
    end else if (rv) begin
      mPc = {rp[31:2], 2'b00}; mBoot = 1'b0; mValid = 1'b0; mInst = 32'd0;
    end else if (mBoot) begin
      mBoot = 1'b0; mValid = 1'b0;
    end else if (f) begin
      mValid = 1'b0; mInst = 32'd0;
      if (!s) mPc = mPc + 32'd4;
    end else if (!s) begin
      mIdPc = mPc; mInst = romWord({2'b00, mPc[31:2]});
      mIdPc4 = mPc + 32'd4; mValid = 1'b1; mPc = mPc + 32'd4;
    end

    e.valid = mValid; e.inst = mInst; e.pc = mIdPc; e.pcPlus4 = mIdPc4;
    e.fault = 1'b0; e.addr = {2'b00, mPc[31:2]};
    scoreboard.push_back(e);

    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = scoreboard.pop_front();
      checkOutput("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
      checkOutput("id_inst", bus.id_inst, e.inst);
      checkOutput("id_pc", bus.id_pc, e.pc);
      checkOutput("id_pc_plus4", bus.id_pc_plus4, e.pcPlus4);
      checkOutput("fault", {31'd0, bus.fault}, {31'd0, e.fault});
      checkOutput("imem_addr", bus.imem_addr, e.addr);
    end
  endtask

  task automatic stepNormal();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    mPc = RESET_PC; mBoot = 1'b1; mValid = 1'b0;
    mInst = 32'd0; mIdPc = 32'd0; mIdPc4 = 32'd0;

    // Reset, BOOT bubble, then the first three fetches.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    stepNormal();
    checkOutput("boot_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("boot_addr", bus.imem_addr, 32'd0);
    stepNormal();
    checkOutput("f0_inst", bus.id_inst, 32'h100);
    checkOutput("f0_pc", bus.id_pc, 32'h0);
    stepNormal();
    checkOutput("f1_inst", bus.id_inst, 32'h101);
    stepNormal();
    checkOutput("f2_inst", bus.id_inst, 32'h102);
    checkOutput("f2_pc", bus.id_pc, 32'h8);

    // Three stalled cycles hold the slot, then fetch resumes at 12.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("stall_pc", bus.id_pc, 32'h8);
      checkOutput("stall_inst", bus.id_inst, 32'h102);
    end
    stepNormal();
    checkOutput("resume_pc", bus.id_pc, 32'hC);

    // Flush at pc=0x10 inserts a bubble but the PC keeps moving.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("flush_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("flush_inst", bus.id_inst, 32'h0);
    stepNormal();
    checkOutput("post_flush_pc", bus.id_pc, 32'h14);

    // Redirect together with stall: redirect wins.
    stepNormal();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    checkOutput("redir_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("redir_addr", bus.imem_addr, 32'h8);
    stepNormal();
    checkOutput("redir_pc", bus.id_pc, 32'h20);
    checkOutput("redir_inst", bus.id_inst, 32'h108);

    // Misaligned target is forced word aligned.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h2A, 1'b0);
    stepNormal();
    checkOutput("align_pc", bus.id_pc, 32'h28);

    // Top of the address space: out-of-range read and 32-bit wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    stepNormal();
    checkOutput("wrap_inst", bus.id_inst, 32'h0);
    checkOutput("wrap_pc4", bus.id_pc_plus4, 32'h0);
    stepNormal();
    checkOutput("wrap_next_pc", bus.id_pc, 32'h0);

    // Flush while stalled holds the PC.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("flush_stall_addr", bus.imem_addr, 32'h1);

    // Reset while stalled with a valid instruction in IF/ID.
    stepNormal();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("rst_mid_valid", {31'd0, bus.id_valid}, 32'd0);
    checkOutput("rst_mid_pc", bus.id_pc, 32'd0);
    checkOutput("rst_mid_addr", bus.imem_addr, 32'd0);
    stepNormal();
    stepNormal();

    // Random mix of control inputs, checked only against the model.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 70) * 4) + $urandom_range(0, 3),
                    ($urandom_range(0, 30) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte PC loaded on reset.
REQ-002 Parameter ADDR_WIDTH, default 6, instruction-memory word-index width; must equal the instruction ROM's ADDR_WIDTH.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold PC and IF/ID register.
REQ-006 flush  in  1  squash IF/ID contents (bubble).
REQ-007 redirect_valid  in  1  branch/jump taken this cycle.
REQ-008 redirect_pc  in  32  byte target PC.
REQ-009 imem_addr  out  32  word address to instruction ROM.
REQ-010 imem_data  in  32  ROM read data, valid before next posedge (ROM latches on negedge).
REQ-011 id_valid  out  1  IF/ID holds a real instruction.
REQ-012 id_inst  out  32  latched instruction.
REQ-013 id_pc  out  32  byte PC of id_inst.
REQ-014 id_pc_plus4  out  32  id_pc + 4.
REQ-015 fault  out  1  sticky fetch fault (IF_FAULT_EN only; else constant 0).

Function
REQ-016 pc register SHALL be byte-addressed; imem_addr SHALL be combinational {2'b00, pc[31:2]}, zero added latency.
REQ-017 FSM states: BOOT, RUN, FAULT; BOOT entered on reset, lasts exactly one cycle, id_valid=0 and pc held, then RUN.
REQ-018 In RUN with no stall/flush/redirect: IF/ID SHALL latch {pc, imem_data, pc+4}, id_valid<=1, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-019 Priority per cycle SHALL be rst > redirect_valid > flush > stall > normal advance.
REQ-020 redirect_valid=1 (any state except during rst): pc<=redirect_pc, id_valid<=0, id_inst<=NOP, regardless of stall; leaves FAULT to RUN.
REQ-021 flush=1 without redirect: id_valid<=0, id_inst<=NOP; pc advances by 4 unless stall=1, in which case pc holds.
REQ-022 stall=1 alone: pc and all id_* outputs SHALL hold their values.
REQ-023 Out-of-range fetch (pc[31:ADDR_WIDTH+2] != 0) SHALL latch imem_data as received (ROM returns 0) when IF_FAULT_EN is undefined.
REQ-024 Instruction throughput SHALL be one per cycle in RUN with no stall.

Reset
REQ-025 On rst: pc<=RESET_PC, state<=BOOT, id_valid<=0, id_inst<=NOP, id_pc<=0, id_pc_plus4<=0, fault<=0.
REQ-026 rst asserted mid-stream SHALL discard in-flight IF/ID contents; no output update other than REQ-025 that cycle.

Configuration
REQ-027 Macro IF_FAULT_EN.
REQ-028 Defined: misaligned pc (pc[1:0]!=0) or out-of-range pc in RUN SHALL enter FAULT next cycle; fault<=1, id_valid<=0, pc held; exit only via redirect_valid or rst, which also clear fault.
REQ-029 Undefined: FAULT state unreachable, fault tied 0, redirect_pc[1:0] forced to 2'b00 when loaded.

Structure
REQ-030 Shared package SHALL hold NOP (32'h0000_0000), FSM state encoding (2-bit BOOT=0, RUN=1, FAULT=2), and the PC increment constant 4.
REQ-031 One sub-module pc_reg (PC register + next-PC mux, redirect/stall inputs); IF/ID register and FSM live in if_stage.

Verification
REQ-032 Reset with RESET_PC=0, ROM words k = 0x100+k: cycle1 id_valid=0; next cycles id_inst 0x100,0x101,0x102 with id_pc 0,4,8.
REQ-033 stall high 3 cycles mid-stream at id_pc=8: id_* hold 8/0x102 for 3 cycles, then id_pc=12 resumes.
REQ-034 redirect_valid with redirect_pc=0x20 together with stall=1: next cycle id_valid=0, imem_addr=8; following cycle id_pc=0x20, id_inst=0x108.
REQ-035 flush alone at pc=0x10: next cycle id_valid=0, id_inst=0; following cycle id_pc=0x14.
REQ-036 IF_FAULT_EN: redirect_pc=0x102 -> next cycle FAULT, fault=1, id_valid=0 held; redirect_pc=0 clears fault; also pc=0x100 (ADDR_WIDTH=6) -> fault=1.
REQ-037 rst asserted while stalled with id_valid=1 -> next cycle all outputs at REQ-025 values, pc=RESET_PC.
